lsu_mem: RTL

- MEM-stage load/store unit, directly downstream of the store-data forwarding select.
- Consumes `D_in_sel` to choose raw rs2 data or WB-stage forwarded data as store data.
- Aligns store data and generates byte write-enables; runs a req/ack handshake to the D-cache; sign/zero-extends load data.
- Stalls the pipeline for the duration of each access.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_mem.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared opcodes, access-size codes, FSM state type and the legality/alignment
// check for the MEM-stage load/store unit.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    // Unsigned loads exist only for byte/halfword; stores have no unsigned forms.
    function automatic logic access_ok(input logic       is_load,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic legal;
        logic aligned;
        legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                (is_load && ((funct3 == F3_BU) || (funct3 == F3_HU)));
        case (funct3[1:0])
            2'b01:   aligned = ~addr_lo[0];
            2'b10:   aligned = (addr_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal & aligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store-data replication with byte enables, and
// load lane select with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_addr_lo_i,
    input  logic [2:0]  st_funct3_i,
    input  logic [31:0] st_src_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_be_o,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [15:0] lane;

    always_comb begin
        st_wdata_o = st_src_i;
        st_be_o    = 4'b1111;
        case (st_funct3_i)
            F3_B: begin
                st_wdata_o = {4{st_src_i[7:0]}};
                st_be_o    = 4'b0001 << st_addr_lo_i;
            end
            F3_H: begin
                st_wdata_o = {2{st_src_i[15:0]}};
                st_be_o    = 4'b0011 << st_addr_lo_i;
            end
            default: ;
        endcase
    end

    // Low 16 bits starting at the addressed byte; lane 3 only ever feeds byte loads.
    always_comb begin
        case (ld_addr_lo_i)
            2'd0:    lane = ld_rdata_i[15:0];
            2'd1:    lane = ld_rdata_i[23:8];
            2'd2:    lane = ld_rdata_i[31:16];
            default: lane = {8'h00, ld_rdata_i[31:24]};
        endcase
    end

    always_comb begin
        ld_data_o = ld_rdata_i;
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{lane[7]}}, lane[7:0]};
            F3_BU:   ld_data_o = {24'h000000, lane[7:0]};
            F3_H:    ld_data_o = {{16{lane[15]}}, lane[15:0]};
            F3_HU:   ld_data_o = {16'h0000, lane[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// MEM-stage load/store unit: D-cache req/ack handshake, pipeline stall, load result.
// Defining LSU_TIMEOUT_EN adds an ack watchdog of TIMEOUT_CYC ACCESS cycles.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [6:0]        opcode_MEM,
    input  logic [2:0]        funct3_MEM,
    input  logic [ADDR_W-1:0] alu_out_MEM,
    input  logic [DATA_W-1:0] rs2_data_MEM,
    input  logic [DATA_W-1:0] wb_data_WB,
    input  logic              D_in_sel,
    output logic              dc_req,
    output logic [3:0]        dc_we,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    input  logic [DATA_W-1:0] dc_rdata,
    input  logic              dc_ack,
    output logic              lsu_stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              misalign_err
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_load_q, is_load_d;
    logic              timed_out_q, timed_out_d;

    logic              is_load, is_store, req_valid, start, bad_access;
    logic [DATA_W-1:0] st_src, st_wdata, ld_ext;
    logic [3:0]        st_be;
    logic              timeout_hit;

    assign is_load  = (opcode_MEM == OP_LOAD);
    assign is_store = (opcode_MEM == OP_STORE);
    // Gated by rst so the combinational stall/error outputs are quiet while in reset.
    assign req_valid  = rst & mem_valid & (is_load | is_store) & (state_q == IDLE);
    assign start      = req_valid & access_ok(is_load, funct3_MEM, alu_out_MEM[1:0]);
    assign bad_access = req_valid & ~access_ok(is_load, funct3_MEM, alu_out_MEM[1:0]);
    assign st_src     = D_in_sel ? wb_data_WB : rs2_data_MEM;

    lsu_align u_align (
        .st_addr_lo_i (alu_out_MEM[1:0]),
        .st_funct3_i  (funct3_MEM),
        .st_src_i     (st_src),
        .st_wdata_o   (st_wdata),
        .st_be_o      (st_be),
        .ld_addr_lo_i (addr_q[1:0]),
        .ld_funct3_i  (funct3_q),
        .ld_rdata_i   (dc_rdata),
        .ld_data_o    (ld_ext)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is zero outside ACCESS, so it is already clear on entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == ACCESS) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == ACCESS) && !dc_ack && (cnt_d == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYC);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        load_data_d  = load_data_q;
        funct3_d     = funct3_q;
        is_load_d    = is_load_q;
        timed_out_d  = timed_out_q;
        dc_req       = 1'b0;
        lsu_stall    = 1'b0;
        load_valid   = 1'b0;
        misalign_err = 1'b0;
        case (state_q)
            IDLE: begin
                misalign_err = bad_access;
                if (start) begin
                    lsu_stall   = 1'b1;
                    addr_d      = alu_out_MEM;
                    we_d        = is_load ? 4'b0000 : st_be;
                    wdata_d     = st_wdata;
                    funct3_d    = funct3_MEM;
                    is_load_d   = is_load;
                    timed_out_d = 1'b0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                dc_req    = 1'b1;
                lsu_stall = 1'b1;
                if (dc_ack) begin
                    if (is_load_q) begin
                        load_data_d = ld_ext;
                    end
                    state_d = DONE;
                end else if (timeout_hit) begin
                    misalign_err = 1'b1;
                    timed_out_d  = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                // One unstalled cycle lets the pipeline move past this instruction.
                load_valid = is_load_q & ~timed_out_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            funct3_q    <= '0;
            is_load_q   <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            funct3_q    <= funct3_d;
            is_load_q   <= is_load_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign dc_we     = (state_q == ACCESS) ? we_q : 4'b0000;
    assign dc_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign dc_wdata  = wdata_q;
    assign load_data = load_data_q;

endmodule
